// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front-end.
// Contents: FSM state type, command encodings (decoded by the RAM, not here),
// default payload width and frame width, and a receive-state helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  // Command field rx_data[9:8]; forwarded untouched to the RAM.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned FRAME_W    = DEF_DATA_W + 2;

  // States in which MOSI frame bits are shifted in.
  function automatic logic is_rx_state(spi_state_e s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_shift_out.sv
// spi_shift_out: DATA_W-bit parallel-in/serial-out register driving MISO.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   synchronous active-high reset
//   i_clear abort: drop any transfer, MISO low next cycle
//   i_load  load i_data; its MSB appears on o_miso the following cycle
//   i_data  parallel read data
//   o_miso  registered serial output, MSB first, 0 when idle
//   o_busy  high while a word is being shifted out
module spi_shift_out #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_miso,
  output logic              o_busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_sr;
  logic [CntW-1:0]   r_left;  // bits still to present after the current one
  logic              r_miso;
  logic              r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_sr   <= '0;
      r_left <= '0;
      r_miso <= 1'b0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      // MSB goes straight to the output register; the rest queue behind it.
      r_sr   <= {i_data[DATA_W-2:0], 1'b0};
      r_miso <= i_data[DATA_W-1];
      r_left <= CntW'(DATA_W - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_left != '0) begin
        r_miso <= r_sr[DATA_W-1];
        r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
        r_left <= r_left - 1'b1;
      end else begin
        r_miso <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end

  assign o_miso = r_miso;
  assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front-end of the SPI RAM subsystem.
// Deserialises MOSI frames {cmd[1:0], payload[DATA_W-1:0]} into rx_data with a
// one-cycle rx_valid strobe, and serialises RAM read data (tx_data/tx_valid)
// MSB-first on MISO. SPI clock and system clock are the same net.
// Ports:
//   clk      clock, rising edge       rst      synchronous active-high reset
//   SS_n     slave select, active low MOSI     serial data in, MSB first
//   MISO     serial data out          rx_data  received word
//   rx_valid one-cycle strobe         tx_data  read data from RAM
//   tx_valid tx_data valid
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned   FrameW  = DATA_W + 2;
  localparam int unsigned   CntW    = $clog2(FrameW + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] DoneCnt = CntW'(FrameW);

  spi_state_e        r_state;
  spi_state_e        w_next_state;
  logic [CntW-1:0]   r_cnt;
  logic [FrameW-2:0] r_shift;
  logic [FrameW-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rd_addr_seen;
  logic              r_await_tx;

  logic w_in_rx;
  logic w_rx_bit;
  logic w_last_bit;
  logic w_abort;
  logic w_load;
  logic w_busy;

  assign w_in_rx    = is_rx_state(r_state);
  assign w_abort    = SS_n && (r_state != IDLE);
  // Counter parks at DoneCnt once a frame is in, so extra MOSI bits are ignored.
  assign w_rx_bit   = w_in_rx && !SS_n && (r_cnt != DoneCnt);
  assign w_last_bit = w_rx_bit && (r_cnt == LastCnt);
  assign w_load     = (r_state == READ_DATA) && !SS_n && r_await_tx && tx_valid && !w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (!SS_n) w_next_state = CHK_CMD;
      end
      CHK_CMD: begin
        // MOSI here is only a routing bit and is not part of the frame word.
        if (SS_n)                w_next_state = IDLE;
        else if (!MOSI)          w_next_state = WRITE;
        else if (r_rd_addr_seen) w_next_state = READ_DATA;
        else                     w_next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_await_tx     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      if (SS_n || !w_in_rx) begin
        r_cnt <= '0;
      end else if (w_rx_bit) begin
        r_cnt   <= r_cnt + 1'b1;
        r_shift <= {r_shift[FrameW-3:0], MOSI};
      end

      if (w_last_bit) begin
        r_rx_data  <= {r_shift, MOSI};
        r_rx_valid <= 1'b1;
        if (r_state == READ_ADD)       r_rd_addr_seen <= 1'b1;
        else if (r_state == READ_DATA) r_rd_addr_seen <= 1'b0;
      end

      // Only the first tx_valid after a completed READ_DATA frame is honoured.
      if (w_abort)                                 r_await_tx <= 1'b0;
      else if (w_last_bit && r_state == READ_DATA) r_await_tx <= 1'b1;
      else if (w_load)                             r_await_tx <= 1'b0;
    end
  end

  spi_shift_out #(
    .DATA_W(DATA_W)
  ) u_shift_out (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clear(w_abort),
    .i_load (w_load),
    .i_data (tx_data),
    .o_miso (MISO),
    .o_busy (w_busy)
  );

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: scoreboard bench for spi_slave_if.
// Stimulus pushes expected rx words and per-cycle MISO bits into queues; a
// negedge monitor pops and compares whenever rx_valid fires, and expects MISO
// low on every cycle with no queued bit.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  typedef struct {
    int   cyc;
    logic b;
  } miso_t;

  logic [9:0] exp_rx[$];
  miso_t      exp_miso[$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  spi_slave_if #(
    .DATA_W(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [9:0] e;
    miso_t      m;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        chk("rx_valid_spurious", 32'(rx_valid), 32'd0);
      end else begin
        e = exp_rx.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e));
      end
    end
    if (exp_miso.size() > 0 && exp_miso[0].cyc == cyc) begin
      m = exp_miso.pop_front();
      chk("miso_bit", 32'(MISO), 32'(m.b));
    end else begin
      chk("miso_idle", 32'(MISO), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SS_n low, routing bit, then 10 frame bits MSB first; ends just after the
  // edge that samples the last bit. stray holds tx_valid high throughout.
  task automatic send_frame(input logic cmd, input logic [9:0] word, input logic stray);
    exp_rx.push_back(word);
    SS_n = 1'b0;
    MOSI = 1'b0;
    if (stray) begin
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
    end
    tick();
    MOSI = cmd;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = word[i];
      tick();
    end
    MOSI     = 1'b0;
    tx_valid = 1'b0;
  endtask

  // Offer read data for 3 cycles (later cycles carry different data that must
  // be ignored); queue the first n MISO bits expected from the first load.
  task automatic read_out(input logic [7:0] b, input int n);
    miso_t m;
    for (int i = 0; i < n; i++) begin
      m.cyc = cyc + 1 + i;
      m.b   = b[7-i];
      exp_miso.push_back(m);
    end
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_data = ~b;
    tick();
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic end_frame();
    repeat (8) tick();
    SS_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic [9:0] abort_word;
    rst      = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();
    tick();
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick();

    // Write address and write data frames.
    send_frame(1'b0, 10'b00_1010_0101, 1'b0);
    end_frame();
    send_frame(1'b0, 10'b01_0011_1100, 1'b0);
    end_frame();

    // Read address: READ_ADD path, so offered read data must not appear.
    send_frame(1'b1, 10'b10_0000_0011, 1'b0);
    read_out(8'h5A, 0);
    end_frame();
    // Read data: 0xC3 shifted out MSB first.
    send_frame(1'b1, 10'b11_0000_0000, 1'b0);
    read_out(8'hC3, 8);
    end_frame();

    // Abort after 5 data bits, then immediate re-select with a full frame.
    abort_word = 10'b11_1110_0000;
    SS_n = 1'b0;
    tick();
    MOSI = 1'b0;
    tick();
    for (int i = 9; i >= 5; i--) begin
      MOSI = abort_word[i];
      tick();
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    send_frame(1'b0, 10'h0FF, 1'b0);
    end_frame();

    // rd_addr_seen was cleared by the READ_DATA frame: this goes to READ_ADD.
    send_frame(1'b1, 10'b10_1010_0101, 1'b0);
    read_out(8'h66, 0);
    end_frame();
    send_frame(1'b1, 10'b11_1010_0101, 1'b0);
    read_out(8'hA5, 3);
    rst  = 1'b1;
    SS_n = 1'b1;
    tick();
    chk("midrst_miso", 32'(MISO), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick();
    // Reset cleared rd_addr_seen: READ_ADD path again.
    send_frame(1'b1, 10'b10_0001_0001, 1'b0);
    read_out(8'h81, 0);
    end_frame();

    // Stray tx_valid during a WRITE frame.
    send_frame(1'b0, 10'b01_0101_0101, 1'b1);
    end_frame();
    repeat (3) tick();
    chk("rx_data_hold", 32'(rx_data), 32'h155);

    tick();
    chk("rx_pending", 32'(exp_rx.size()), 32'd0);
    chk("miso_pending", 32'(exp_miso.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
